// File: rtl/parity_stripe_engine.sv
// parity_stripe_engine: XORs two 128-byte stripe lines into a parity line
// and serves it on the buffer-read port for the parity write command.
//
// Ports:
//   clock, reset (async, active-low)
//   start, stripe1_tag, stripe2_tag, parity_tag : arm engine, latch tags
//   bw_valid/bw_tag/bw_address/bw_data : stripe data from buffer-write
//   br_valid/br_tag/br_address -> br_data/br_parity : 1-cycle read path
//   resp_valid/resp_tag/resp_code : command responses (0 = DONE)
//   busy, ready, done, error : status back to the work element
module parity_stripe_engine #(
    parameter int LINE_HALVES = 2
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         start,
    input  logic [7:0]   stripe1_tag,
    input  logic [7:0]   stripe2_tag,
    input  logic [7:0]   parity_tag,
    input  logic         bw_valid,
    input  logic [7:0]   bw_tag,
    input  logic [5:0]   bw_address,
    input  logic [511:0] bw_data,
    input  logic         br_valid,
    input  logic [7:0]   br_tag,
    input  logic [5:0]   br_address,
    output logic [511:0] br_data,
    output logic         br_parity,
    input  logic         resp_valid,
    input  logic [7:0]   resp_tag,
    input  logic [7:0]   resp_code,
    output logic         busy,
    output logic         ready,
    output logic         done,
    output logic         error
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_COLLECT,
        S_READY,
        S_ERROR
    } state_t;

    state_t state, state_nxt;

    logic [7:0]   tag1_q, tag2_q, ptag_q;
    logic [511:0] acc [LINE_HALVES];

    logic [LINE_HALVES-1:0] seen1_q, seen1_nxt;
    logic [LINE_HALVES-1:0] seen2_q, seen2_nxt;
    logic resp1_q, resp1_nxt;
    logic resp2_q, resp2_nxt;

    logic arm, wr_en, done_nxt;
    logic half;
    logic line_ok;
    logic hit1, hit2;
    logic r1, r2, rp;
    logic code_ok;

    // Only the half-line index of the read is meaningful; the tag is not.
    logic unused_br;
    assign unused_br = ^{br_tag, br_address[5:1]};

    assign half    = bw_address[0];
    assign line_ok = (bw_address[5:1] == 5'd0);
    assign hit1    = bw_valid && line_ok && (bw_tag == tag1_q);
    assign hit2    = bw_valid && line_ok && (bw_tag == tag2_q);
    assign r1      = resp_valid && (resp_tag == tag1_q);
    assign r2      = resp_valid && (resp_tag == tag2_q);
    assign rp      = resp_valid && (resp_tag == ptag_q);
    assign code_ok = (resp_code == 8'd0);

    assign br_parity = ~^br_data;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        seen1_nxt = seen1_q;
        seen2_nxt = seen2_q;
        resp1_nxt = resp1_q;
        resp2_nxt = resp2_q;
        arm       = 1'b0;
        wr_en     = 1'b0;
        done_nxt  = 1'b0;
        busy      = 1'b0;
        ready     = 1'b0;
        error     = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (start) begin
                    arm       = 1'b1;
                    state_nxt = S_COLLECT;
                end
            end
            S_ERROR: begin
                error = 1'b1;
                if (start) begin
                    arm       = 1'b1;
                    state_nxt = S_COLLECT;
                end
            end
            S_COLLECT: begin
                busy = 1'b1;
                // First write of each stripe half is folded in;
                // repeats are dropped so a retry cannot cancel data.
                if (hit1) begin
                    wr_en           = !seen1_q[half];
                    seen1_nxt[half] = 1'b1;
                end else if (hit2) begin
                    wr_en           = !seen2_q[half];
                    seen2_nxt[half] = 1'b1;
                end
                if (r1 && code_ok) resp1_nxt = 1'b1;
                if (r2 && code_ok) resp2_nxt = 1'b1;
                if ((r1 || r2) && !code_ok) begin
                    state_nxt = S_ERROR;
                end else if (&seen1_nxt && &seen2_nxt &&
                             resp1_nxt && resp2_nxt) begin
                    state_nxt = S_READY;
                end
            end
            S_READY: begin
                busy  = 1'b1;
                ready = 1'b1;
                if (rp) begin
                    if (code_ok) begin
                        state_nxt = S_IDLE;
                        done_nxt  = 1'b1;
                    end else begin
                        state_nxt = S_ERROR;
                    end
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < LINE_HALVES; i++) acc[i] <= '0;
            tag1_q  <= '0;
            tag2_q  <= '0;
            ptag_q  <= '0;
            seen1_q <= '0;
            seen2_q <= '0;
            resp1_q <= 1'b0;
            resp2_q <= 1'b0;
            br_data <= '0;
            done    <= 1'b0;
        end else begin
            done <= done_nxt;
            // Reads sample acc before this edge's write lands.
            if (br_valid) br_data <= acc[br_address[0]];
            if (arm) begin
                for (int i = 0; i < LINE_HALVES; i++) acc[i] <= '0;
                tag1_q  <= stripe1_tag;
                tag2_q  <= stripe2_tag;
                ptag_q  <= parity_tag;
                seen1_q <= '0;
                seen2_q <= '0;
                resp1_q <= 1'b0;
                resp2_q <= 1'b0;
            end else begin
                seen1_q <= seen1_nxt;
                seen2_q <= seen2_nxt;
                resp1_q <= resp1_nxt;
                resp2_q <= resp2_nxt;
                if (wr_en) acc[half] <= acc[half] ^ bw_data;
            end
        end
    end

endmodule

// File: tb/tb_parity_stripe_engine.sv
// tb_parity_stripe_engine: directed + randomized checks of the parity
// stripe engine against a line-level XOR reference model.
module tb_parity_stripe_engine;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic [7:0]   stripe1_tag = '0;
    logic [7:0]   stripe2_tag = '0;
    logic [7:0]   parity_tag = '0;
    logic         bw_valid = 1'b0;
    logic [7:0]   bw_tag = '0;
    logic [5:0]   bw_address = '0;
    logic [511:0] bw_data = '0;
    logic         br_valid = 1'b0;
    logic [7:0]   br_tag = '0;
    logic [5:0]   br_address = '0;
    logic [511:0] br_data;
    logic         br_parity;
    logic         resp_valid = 1'b0;
    logic [7:0]   resp_tag = '0;
    logic [7:0]   resp_code = '0;
    logic         busy, ready, done, error;

    int n_checks = 0;
    int n_fail = 0;

    parity_stripe_engine dut (
        .clock(clock), .reset(reset), .start(start),
        .stripe1_tag(stripe1_tag), .stripe2_tag(stripe2_tag),
        .parity_tag(parity_tag),
        .bw_valid(bw_valid), .bw_tag(bw_tag),
        .bw_address(bw_address), .bw_data(bw_data),
        .br_valid(br_valid), .br_tag(br_tag),
        .br_address(br_address), .br_data(br_data),
        .br_parity(br_parity),
        .resp_valid(resp_valid), .resp_tag(resp_tag),
        .resp_code(resp_code),
        .busy(busy), .ready(ready), .done(done), .error(error)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [511:0] obs,
                       input logic [511:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic arm(input logic [7:0] t1, input logic [7:0] t2,
                       input logic [7:0] t3);
        stripe1_tag = t1;
        stripe2_tag = t2;
        parity_tag  = t3;
        start       = 1'b1;
        tick();
        start       = 1'b0;
    endtask

    task automatic bw(input logic [7:0] t, input logic [5:0] a,
                      input logic [511:0] d);
        bw_valid   = 1'b1;
        bw_tag     = t;
        bw_address = a;
        bw_data    = d;
        tick();
        bw_valid   = 1'b0;
    endtask

    task automatic rsp(input logic [7:0] t, input logic [7:0] c);
        resp_valid = 1'b1;
        resp_tag   = t;
        resp_code  = c;
        tick();
        resp_valid = 1'b0;
    endtask

    task automatic rd(input logic [5:0] a);
        br_valid   = 1'b1;
        br_tag     = 8'h77;
        br_address = a;
        tick();
        br_valid   = 1'b0;
    endtask

    function automatic logic [511:0] rand512();
        logic [511:0] v;
        for (int i = 0; i < 16; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    // Reference: parity half = XOR of first-received stripe halves.
    logic [511:0] s1 [2];
    logic [511:0] s2 [2];
    logic [511:0] expv;
    logic [511:0] junk;
    logic [7:0]   ta;

    initial begin
        #1 reset = 1'b0;
        #20;
        chk("rst_busy", busy, 0);
        chk("rst_ready", ready, 0);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);
        chk("rst_br_data", br_data, 0);
        chk("rst_br_parity", br_parity, 1);
        reset = 1'b1;
        tick();

        // Basic 0xAA ^ 0xFF parity line.
        arm(8'd1, 8'd2, 8'd3);
        chk("arm_busy", busy, 1);
        chk("arm_ready", ready, 0);
        bw(8'd1, 6'd0, {64{8'hAA}});
        bw(8'd1, 6'd1, {64{8'hAA}});
        bw(8'd2, 6'd0, {64{8'hFF}});
        bw(8'd2, 6'd1, {64{8'hFF}});
        chk("data_only_ready", ready, 0);
        rsp(8'd1, 8'd0);
        chk("one_resp_ready", ready, 0);
        rsp(8'd2, 8'd0);
        chk("basic_ready", ready, 1);
        chk("basic_busy", busy, 1);
        expv = {64{8'h55}};
        rd(6'd0);
        chk("basic_rd0", br_data, expv);
        chk("basic_par0", br_parity, ~^expv);
        rd(6'd1);
        chk("basic_rd1", br_data, expv);
        chk("basic_par1", br_parity, ~^expv);

        rsp(8'd3, 8'd0);
        chk("pdone_done", done, 1);
        chk("pdone_busy", busy, 0);
        chk("pdone_ready", ready, 0);
        tick();
        chk("pdone_pulse", done, 0);

        // Duplicates / foreign tags / early responses.
        arm(8'd1, 8'd2, 8'd3);
        rd(6'd0);
        chk("rearm_zero", br_data, 0);
        s1[0] = rand512();
        s1[1] = rand512();
        s2[0] = rand512();
        s2[1] = rand512();
        junk  = rand512();
        bw(8'd1, 6'd0, s1[0]);
        bw(8'd1, 6'd0, junk);
        bw(8'd9, 6'd0, junk);
        bw(8'd1, 6'd2, junk);
        rd(6'd0);
        chk("dup_ignored", br_data, s1[0]);
        rsp(8'd1, 8'd0);
        rsp(8'd2, 8'd0);
        chk("early_resp_ready", ready, 0);
        bw(8'd1, 6'd1, s1[1]);
        bw(8'd2, 6'd0, s2[0]);
        chk("three_halves_ready", ready, 0);
        // Final write with a same-cycle read of that half.
        bw_valid   = 1'b1;
        bw_tag     = 8'd2;
        bw_address = 6'd1;
        bw_data    = s2[1];
        br_valid   = 1'b1;
        br_address = 6'd1;
        tick();
        bw_valid   = 1'b0;
        br_valid   = 1'b0;
        chk("rw_same_half", br_data, s1[1]);
        chk("final_ready", ready, 1);
        rd(6'd0);
        chk("early_rd0", br_data, s1[0] ^ s2[0]);
        rd(6'd1);
        chk("early_rd1", br_data, s1[1] ^ s2[1]);
        rsp(8'd3, 8'd0);
        chk("early_done", done, 1);

        // Error path and recovery.
        arm(8'd1, 8'd2, 8'd3);
        bw(8'd1, 6'd0, rand512());
        rsp(8'd2, 8'h05);
        chk("err_error", error, 1);
        chk("err_busy", busy, 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("err_clear", error, 0);
        chk("err_rearm_busy", busy, 1);
        rd(6'd0);
        chk("err_acc_zero", br_data, 0);

        // Asynchronous reset mid-COLLECT.
        bw(8'd1, 6'd0, {64{8'h3C}});
        rd(6'd0);
        chk("pre_rst_data", br_data, {64{8'h3C}});
        reset = 1'b0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_ready", ready, 0);
        chk("arst_error", error, 0);
        chk("arst_br_data", br_data, 0);
        #1 reset = 1'b1;
        tick();
        rd(6'd0);
        chk("post_rst_rd", br_data, 0);
        arm(8'd4, 8'd5, 8'd6);
        chk("post_rst_busy", busy, 1);
        rsp(8'd4, 8'h80);
        chk("post_rst_err", error, 1);

        // Randomized lines, stripe 2 written before stripe 1.
        for (int it = 0; it < 4; it++) begin
            ta = 8'($urandom_range(0, 84));
            for (int h = 0; h < 2; h++) begin
                s1[h] = rand512();
                s2[h] = rand512();
            end
            arm(ta, ta + 8'd85, ta + 8'd170);
            chk("rnd_busy", busy, 1);
            bw(ta + 8'd85, 6'd1, s2[1]);
            bw(ta + 8'd85, 6'd0, s2[0]);
            bw(ta, 6'd1, s1[1]);
            bw(ta, 6'd0, s1[0]);
            rsp(ta + 8'd85, 8'd0);
            chk("rnd_not_ready", ready, 0);
            rsp(ta, 8'd0);
            chk("rnd_ready", ready, 1);
            for (int h = 0; h < 2; h++) begin
                rd(6'(h));
                expv = s1[h] ^ s2[h];
                chk("rnd_data", br_data, expv);
                chk("rnd_parity", br_parity, ~^expv);
            end
            rsp(ta + 8'd170, 8'd0);
            chk("rnd_done", done, 1);
            chk("rnd_idle", busy, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
